// File: rtl/vector_multiplier_pipe.sv
// Pipelined SIMD multiplier: per-lane signed/unsigned products for 8/16/32(/64)-bit elements,
// elastic valid/ready pipeline of STAGES slots, opaque tag carried with each operation.
module vector_multiplier_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         sew,
  input  logic               a_signed,
  input  logic               b_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [TAG_W-1:0]   out_tag,
  output logic               illegal,
  output logic               busy
);

  localparam int RW   = 2 * WIDTH;
  localparam int NSEW = (WIDTH == 64) ? 4 : 3;

  logic               sew_ok;
  logic [1:0]         sew_idx;
  logic [3:0][RW-1:0] pp0_sew;
  logic [3:0][RW-1:0] pp1_sew;
  logic [3:0][RW-1:0] sum_sew;

  logic [STAGES-1:0]  v_reg;
  logic [STAGES-1:0]  ill_reg;
  logic [RW-1:0]      pp0_reg [STAGES];
  logic [RW-1:0]      pp1_reg [STAGES];
  logic [1:0]         idx_reg [STAGES];
  logic [TAG_W-1:0]   tag_reg [STAGES];

  logic [STAGES-1:0]  load_ok;
  logic [STAGES-1:0]  up_v;
  logic [STAGES-1:0]  up_ill;
  logic [RW-1:0]      up_pp0 [STAGES];
  logic [RW-1:0]      up_pp1 [STAGES];
  logic [1:0]         up_idx [STAGES];
  logic [TAG_W-1:0]   up_tag [STAGES];

  always_comb begin
    sew_ok  = 1'b0;
    sew_idx = 2'd0;
    case (sew)
      4'b0001: begin sew_ok = 1'b1; sew_idx = 2'd0; end
      4'b0010: begin sew_ok = 1'b1; sew_idx = 2'd1; end
      4'b0100: begin sew_ok = 1'b1; sew_idx = 2'd2; end
      4'b1000: begin sew_ok = (WIDTH == 64); sew_idx = 2'd3; end
      default: begin sew_ok = 1'b0; sew_idx = 2'd0; end
    endcase
  end

  // Lane product = pp0 + pp1 (mod 2^2e): pp0 = ext(A) * B, pp1 = (-A) << e when B is negative signed.
  for (genvar gs = 0; gs < 4; gs++) begin : g_sew
    localparam int E = 8 << gs;
    if (gs < NSEW) begin : g_legal
      for (genvar gi = 0; gi < WIDTH / E; gi++) begin : g_lane
        logic [E-1:0]   la;
        logic [E-1:0]   lb;
        logic [E-1:0]   neg_a;
        logic [2*E-1:0] la_ext;
        logic           b_neg;
        assign la     = a[E*gi +: E];
        assign lb     = b[E*gi +: E];
        assign neg_a  = -la;
        assign la_ext = {{E{a_signed & la[E-1]}}, la};
        assign b_neg  = b_signed & lb[E-1];
        assign pp0_sew[gs][2*E*gi +: 2*E] = la_ext * {{E{1'b0}}, lb};
        assign pp1_sew[gs][2*E*gi +: 2*E] = {(b_neg ? neg_a : {E{1'b0}}), {E{1'b0}}};
        assign sum_sew[gs][2*E*gi +: 2*E] = pp0_reg[STAGES-1][2*E*gi +: 2*E]
                                          + pp1_reg[STAGES-1][2*E*gi +: 2*E];
      end
    end else begin : g_none
      assign pp0_sew[gs] = '0;
      assign pp1_sew[gs] = '0;
      assign sum_sew[gs] = '0;
    end
  end

  // A slot can load when it is empty or its occupant moves on this cycle.
  always_comb begin
    load_ok[STAGES-1] = !v_reg[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      load_ok[k] = !v_reg[k] || load_ok[k+1];
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_up
    if (gi == 0) begin : g_head
      assign up_v[0]   = in_valid;
      assign up_ill[0] = !sew_ok;
      assign up_pp0[0] = sew_ok ? pp0_sew[sew_idx] : '0;
      assign up_pp1[0] = sew_ok ? pp1_sew[sew_idx] : '0;
      assign up_idx[0] = sew_idx;
      assign up_tag[0] = in_tag;
    end else begin : g_body
      assign up_v[gi]   = v_reg[gi-1];
      assign up_ill[gi] = ill_reg[gi-1];
      assign up_pp0[gi] = pp0_reg[gi-1];
      assign up_pp1[gi] = pp1_reg[gi-1];
      assign up_idx[gi] = idx_reg[gi-1];
      assign up_tag[gi] = tag_reg[gi-1];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      v_reg   <= '0;
      ill_reg <= '0;
      for (int k = 0; k < STAGES; k++) begin
        pp0_reg[k] <= '0;
        pp1_reg[k] <= '0;
        idx_reg[k] <= '0;
        tag_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load_ok[k]) begin
          v_reg[k] <= up_v[k];
          if (up_v[k]) begin
            ill_reg[k] <= up_ill[k];
            pp0_reg[k] <= up_pp0[k];
            pp1_reg[k] <= up_pp1[k];
            idx_reg[k] <= up_idx[k];
            tag_reg[k] <= up_tag[k];
          end
        end
      end
    end
  end

  assign in_ready  = load_ok[0];
  assign out_valid = v_reg[STAGES-1];
  assign result    = sum_sew[idx_reg[STAGES-1]];
  assign out_tag   = tag_reg[STAGES-1];
  assign illegal   = ill_reg[STAGES-1];
  assign busy      = |v_reg;

endmodule

// File: tb/tb_vector_multiplier_pipe.sv
// Self-checking bench: three configurations (32/2, 64/1, 64/4) each driven with directed and
// random operations and checked every cycle against a lane-arithmetic reference model.
module tb_vector_multiplier_pipe;

  typedef struct packed {
    logic [127:0] res;
    logic [3:0]   tag;
    logic         ill;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input int cfg, input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL cfg%0d %s: got %h expected %h", cfg, name, act, exp);
    end
  endfunction

  // Reference: each lane operand extended by its signedness, multiplied, kept mod 2^(2e).
  function automatic exp_t model_op(input logic [63:0] aa, input logic [63:0] bb,
                                    input logic [3:0] s, input bit as_, input bit bs_,
                                    input logic [3:0] t, input int w);
    exp_t r;
    int e;
    logic [127:0] ai, bi, me, m2, p;
    case (s)
      4'b0001: e = 8;
      4'b0010: e = 16;
      4'b0100: e = 32;
      4'b1000: e = 64;
      default: e = 0;
    endcase
    r.res = '0;
    r.tag = t;
    r.ill = (e == 0) || (e > w);
    if (!r.ill) begin
      me = (128'd1 << e) - 128'd1;
      m2 = (e == 64) ? {128{1'b1}} : ((128'd1 << (2 * e)) - 128'd1);
      for (int i = 0; i < w / e; i++) begin
        ai = ({64'd0, aa} >> (e * i)) & me;
        bi = ({64'd0, bb} >> (e * i)) & me;
        if (as_ && ai[e-1]) ai = ai | ~me;
        if (bs_ && bi[e-1]) bi = bi | ~me;
        p = (ai * bi) & m2;
        r.res = r.res | (p << (2 * e * i));
      end
    end
    return r;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int W = (gi == 0) ? 32 : 64;
    localparam int S = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);

    logic           rst_n;
    logic           in_valid, in_ready, a_signed, b_signed;
    logic           out_valid, out_ready, illegal, busy;
    logic [W-1:0]   a, b;
    logic [3:0]     sew, in_tag, out_tag;
    logic [2*W-1:0] result;

    bit   done     = 1'b0;
    bit   rand_rdy = 1'b0;
    bit   saw_drop = 1'b0;
    int   stall_cnt = 0;
    exp_t q[$];

    vector_multiplier_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(4)) dut (
      .clock(clk), .reset(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sew(sew), .a_signed(a_signed), .b_signed(b_signed),
      .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .out_tag(out_tag), .illegal(illegal), .busy(busy)
    );

    initial begin
      out_ready = 1'b1;
      forever begin
        @(negedge clk);
        if (stall_cnt > 0) begin
          out_ready = 1'b0;
          stall_cnt--;
        end else if (rand_rdy) begin
          out_ready = ($urandom_range(0, 9) < 7);
        end else begin
          out_ready = 1'b1;
        end
      end
    end

    // Values sampled here are exactly those the next rising edge will see.
    initial begin
      exp_t e;
      forever begin
        @(negedge clk);
        #3;
        if (!rst_n) begin
          q.delete();
          continue;
        end
        chk(gi, "in_ready", 128'(in_ready), 128'((q.size() < S) || out_ready));
        chk(gi, "busy", 128'(busy), 128'(q.size() != 0));
        if (in_valid && !in_ready) saw_drop = 1'b1;
        if (out_valid) begin
          if (q.size() == 0) begin
            chk(gi, "spurious_out_valid", 128'(out_valid), 128'd0);
          end else begin
            e = q[0];
            chk(gi, "result", 128'(result), e.res);
            chk(gi, "out_tag", 128'(out_tag), 128'(e.tag));
            chk(gi, "illegal", 128'(illegal), 128'(e.ill));
            if (out_ready) begin
              $display("cfg%0d op tag=%h result=%h illegal=%b", gi, out_tag, result, illegal);
              void'(q.pop_front());
            end
          end
        end
        if (in_valid && in_ready)
          q.push_back(model_op(64'(a), 64'(b), sew, a_signed, b_signed, in_tag, W));
      end
    end

    task automatic send(input logic [63:0] aa, input logic [63:0] bb, input logic [3:0] s,
                        input bit as_, input bit bs_, input logic [3:0] t);
      int waited;
      @(negedge clk);
      in_valid = 1'b1;
      a = aa[W-1:0];
      b = bb[W-1:0];
      sew = s;
      a_signed = as_;
      b_signed = bs_;
      in_tag = t;
      waited = 0;
      #2;
      while (!in_ready && waited < 300) begin
        @(negedge clk);
        #2;
        waited++;
      end
      if (!in_ready) begin
        chk(gi, "accept_timeout_in_ready", 128'(in_ready), 128'd1);
        in_valid = 1'b0;
      end else begin
        @(posedge clk);
      end
    endtask

    task automatic drain();
      int waited;
      waited = 0;
      while (q.size() != 0 && waited < 500) begin
        @(negedge clk);
        waited++;
      end
      chk(gi, "drain_pending", 128'(q.size()), 128'd0);
    endtask

    task automatic run_lit(input int idx, input logic [63:0] aa, input logic [63:0] bb,
                           input logic [3:0] s, input bit as_, input bit bs_,
                           input logic [127:0] er, input bit eill);
      int cnt;
      bit seen;
      send(aa, bb, s, as_, bs_, 4'(idx));
      cnt = 0;
      seen = 1'b0;
      while (!seen && cnt < 50) begin
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        cnt++;
        if (out_valid) seen = 1'b1;
      end
      chk(gi, $sformatf("latency_lit%0d", idx), 128'(cnt), 128'(S));
      if (seen) begin
        chk(gi, $sformatf("result_lit%0d", idx), 128'(result), er);
        chk(gi, $sformatf("illegal_lit%0d", idx), 128'(illegal), 128'(eill));
      end
      @(posedge clk);
    endtask

    logic [63:0]  la   [8] = '{64'h0203FF10, 64'h0203FF10, 64'hFFFFFFFF, 64'hFFFFFFFF,
                               64'h0000FFFF, 64'h12345678, 64'h12345678, 64'hFFFFFFFF};
    logic [63:0]  lb   [8] = '{64'h0504FF03, 64'h0504FF03, 64'hFFFFFFFF, 64'hFFFFFFFF,
                               64'h0000FFFF, 64'h9ABCDEF0, 64'h9ABCDEF0, 64'hFFFFFFFF};
    logic [3:0]   ls   [8] = '{4'b0001, 4'b0001, 4'b0100, 4'b0100,
                               4'b0010, 4'b0011, 4'b0000, 4'b1000};
    bit           las  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bit           lbs  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [127:0] lr   [8] = '{128'h000A000CFE010030, 128'h000A000C00010030,
                               128'hFFFFFFFE00000001, 128'h1, 128'hFFFF0001, 128'h0, 128'h0,
                               (W == 32) ? 128'h0 : 128'hFFFFFFFE00000001};
    bit           lill [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, (W == 32)};
    logic [3:0]   sews [10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011,
                                4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
      logic [63:0] ra, rb;
      int nfly;
      rst_n = 1'b0;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      sew = 4'b0001;
      a_signed = 1'b0;
      b_signed = 1'b0;
      in_tag = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2;
      chk(gi, "reset_out_valid", 128'(out_valid), 128'd0);
      chk(gi, "reset_result", 128'(result), 128'd0);
      chk(gi, "reset_out_tag", 128'(out_tag), 128'd0);
      chk(gi, "reset_illegal", 128'(illegal), 128'd0);
      chk(gi, "reset_busy", 128'(busy), 128'd0);
      chk(gi, "reset_in_ready", 128'(in_ready), 128'd1);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++)
        run_lit(i, la[i], lb[i], ls[i], las[i], lbs[i], lr[i], lill[i]);

      for (int i = 0; i < 8; i++)
        send({$urandom, $urandom}, {$urandom, $urandom}, sews[i % 4], 1'b0, 1'b0, 4'(i));
      @(negedge clk);
      in_valid = 1'b0;
      drain();

      // Back-pressure: output held off long enough that the pipeline fills.
      @(posedge clk);
      stall_cnt = S + 2;
      saw_drop = 1'b0;
      for (int t = 0; t < 5; t++)
        send({$urandom, $urandom}, {$urandom, $urandom}, 4'b0001, 1'b1, 1'b0, 4'(t));
      @(negedge clk);
      in_valid = 1'b0;
      drain();
      chk(gi, "in_ready_dropped", 128'(saw_drop), 128'd1);

      // Reset with operations in flight: none of them may emerge.
      @(posedge clk);
      stall_cnt = 1000;
      nfly = (S >= 2) ? 2 : 1;
      for (int i = 0; i < nfly; i++)
        send({$urandom, $urandom}, {$urandom, $urandom}, 4'b0010, 1'b0, 1'b1, 4'(8 + i));
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      stall_cnt = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        #2;
        chk(gi, "post_reset_out_valid", 128'(out_valid), 128'd0);
        chk(gi, "post_reset_busy", 128'(busy), 128'd0);
        chk(gi, "post_reset_in_ready", 128'(in_ready), 128'd1);
      end

      rand_rdy = 1'b1;
      for (int n = 0; n < 150; n++) begin
        if ($urandom_range(0, 4) == 0) begin
          @(negedge clk);
          in_valid = 1'b0;
        end else begin
          ra = {$urandom, $urandom};
          rb = {$urandom, $urandom};
          if ($urandom_range(0, 3) == 0) ra = '1;
          if ($urandom_range(0, 3) == 0) rb = '1;
          send(ra, rb, sews[$urandom_range(0, 9)], 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
      end
      @(negedge clk);
      in_valid = 1'b0;
      rand_rdy = 1'b0;
      drain();
      done = 1'b1;
    end
  end

  initial begin
    wait (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: run not complete at time limit, got busy expected done");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
